id_hazard_ctrl: RTL

- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Sits beside the ID-stage operand forwarding unit and the ID-stage branch comparator. Consumes the same IF/ID, ID/EX and EX/MEM register-address fields.
- Decides per cycle whether PC and IF/ID advance, hold or flush, and whether ID/EX receives a bubble.
- Also handles the data-memory ready handshake (whole-pipeline freeze with timeout) and keeps saturating stall/flush performance counters.

---
 rtl/id_hazard_ctrl_pkg.sv | 26 ++
 rtl/sat_counter.sv | 20 ++
 rtl/id_hazard_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types, constants and helpers for the ID-stage hazard controller.
package id_hazard_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam int         CNT_W_DEF    = 32;
  localparam int         MAX_WAIT_DEF = 16;
  localparam int         WAIT_W_DEF   = 5;

  // True when a producer register feeds an operand the ID instruction actually
  // reads; $0 is hardwired to zero, so it never creates a dependence.
  function automatic logic reg_match(
    input logic [4:0] r,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       use_rs,
    input logic       use_rt
  );
    return (r != REG_ZERO) && (((r == rs) && use_rs) || ((r == rt) && use_rt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  // Count one event per enabled cycle, holding once the maximum is reached.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != '1)) begin
      o_cnt <= o_cnt + W'(1);
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Stall/flush/freeze decision logic for the ID stage of the 5-stage MIPS core,
// with a memory-wait FSM, sticky timeout flag and performance counters.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int WAIT_W   = WAIT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_IF_ID_Rs,
  input  logic [4:0]       i_IF_ID_Rt,
  input  logic             i_ID_use_rs,
  input  logic             i_ID_use_rt,
  input  logic             i_ID_branch,
  input  logic             i_ID_taken,
  input  logic [4:0]       i_ID_EX_Rd,
  input  logic             i_ID_EX_reg_write,
  input  logic             i_ID_EX_mem_read,
  input  logic [4:0]       i_EX_MEM_Rd,
  input  logic             i_EX_MEM_mem_read,
  input  logic             i_EX_MEM_mem_req,
  input  logic             i_dmem_ready,
  output logic             o_PC_write,
  output logic             o_IF_ID_write,
  output logic             o_IF_ID_flush,
  output logic             o_ID_EX_bubble,
  output logic             o_pipe_freeze,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              ex_match;
  logic              mem_match;
  logic              load_use;
  logic              branch_on_alu;
  logic              branch_on_load;
  logic              stall;
  logic              freeze;
  logic              stall_inc;

  assign ex_match  = reg_match(i_ID_EX_Rd, i_IF_ID_Rs, i_IF_ID_Rt, i_ID_use_rs, i_ID_use_rt);
  assign mem_match = reg_match(i_EX_MEM_Rd, i_IF_ID_Rs, i_IF_ID_Rt, i_ID_use_rs, i_ID_use_rt);

  // A branch compares in ID, so it must also wait for ALU results in EX and
  // for load data still in MEM; ordinary instructions only wait on a load in EX.
  assign load_use       = i_ID_EX_mem_read && ex_match;
  assign branch_on_alu  = i_ID_branch && i_ID_EX_reg_write && ex_match;
  assign branch_on_load = i_ID_branch && i_EX_MEM_mem_read && mem_match;
  assign stall          = load_use || branch_on_alu || branch_on_load;
  assign freeze         = i_EX_MEM_mem_req && !i_dmem_ready;
  assign stall_inc      = stall && !freeze;

  // Prioritised pipeline controls: reset, memory freeze, data stall, taken flush.
  always_comb begin
    o_PC_write     = 1'b1;
    o_IF_ID_write  = 1'b1;
    o_IF_ID_flush  = 1'b0;
    o_ID_EX_bubble = 1'b0;
    o_pipe_freeze  = 1'b0;
    if (!i_rst_n) begin
      o_PC_write     = 1'b0;
      o_IF_ID_write  = 1'b0;
      o_ID_EX_bubble = 1'b1;
    end else if (freeze) begin
      o_PC_write    = 1'b0;
      o_IF_ID_write = 1'b0;
      o_pipe_freeze = 1'b1;
    end else if (stall) begin
      o_PC_write     = 1'b0;
      o_IF_ID_write  = 1'b0;
      o_ID_EX_bubble = 1'b1;
    end else if (i_ID_taken) begin
      o_IF_ID_flush = 1'b1;
    end
  end

  // Memory-wait FSM: tracks freeze episodes and raises a sticky timeout once
  // the freeze has lasted MAX_WAIT consecutive cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= RUN;
      wait_cnt      <= '0;
      o_mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN:     if (freeze)  state <= WAIT;
        WAIT:    if (!freeze) state <= RUN;
        default: state <= RUN;
      endcase
      if (freeze) begin
        if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) o_mem_timeout <= 1'b1;
        if (wait_cnt != WAIT_W'(MAX_WAIT))     wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (stall_inc),
    .o_cnt   (o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (o_IF_ID_flush),
    .o_cnt   (o_flush_cnt)
  );

endmodule
